// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants: ALU op codes, branch funct3 codes, forward selects.
package riscv_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned FWD_W    = 2;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned SHAMT_W  = 5;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_PCADD = 4'd11;

  localparam logic [FUNCT3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_BGEU = 3'b111;

  localparam logic [FWD_W-1:0] FWD_IDEX  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b01;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU; unused op codes yield zero.
module alu
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  input  logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     result
);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << shamt;
      ALU_SLT:   result = XLEN'($signed(a) < $signed(b));
      ALU_SLTU:  result = XLEN'(a < b);
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_PASSB: result = b;
      ALU_PCADD: result = pc + b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump redirect and the EX/MEM register.
module ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                idex_valid,
  input  logic [XLEN-1:0]     idex_pc,
  input  logic [XLEN-1:0]     idex_rs1_data,
  input  logic [XLEN-1:0]     idex_rs2_data,
  input  logic [XLEN-1:0]     idex_imm,
  input  logic [REG_W-1:0]    idex_rd,
  input  logic [ALU_OP_W-1:0] idex_alu_op,
  input  logic                idex_alusrc,
  input  logic                idex_regwr,
  input  logic                idex_memrd,
  input  logic                idex_memwr,
  input  logic                idex_memtoreg,
  input  logic [FUNCT3_W-1:0] idex_funct3,
  input  logic                idex_branch,
  input  logic                idex_jal,
  input  logic                idex_jalr,
  input  logic [FWD_W-1:0]    forwardA,
  input  logic [FWD_W-1:0]    forwardB,
  input  logic [XLEN-1:0]     memwb_wr_data,
  output logic                exmem_valid,
  output logic [XLEN-1:0]     exmem_alu_result,
  output logic [XLEN-1:0]     exmem_store_data,
  output logic [REG_W-1:0]    exmem_rd,
  output logic                exmem_regwr,
  output logic                exmem_memrd,
  output logic                exmem_memwr,
  output logic                exmem_memtoreg,
  output logic [FUNCT3_W-1:0] exmem_funct3,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc
);

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] ex_result;
  logic            taken;
  logic            is_jump;

  // Operand forwarding; code 11 falls back to the ID/EX value
  always_comb begin
    fwd_rs1 = idex_rs1_data;
    case (forwardA)
      FWD_EXMEM: fwd_rs1 = exmem_alu_result;
      FWD_MEMWB: fwd_rs1 = memwb_wr_data;
      default:   fwd_rs1 = idex_rs1_data;
    endcase
  end

  always_comb begin
    fwd_rs2 = idex_rs2_data;
    case (forwardB)
      FWD_EXMEM: fwd_rs2 = exmem_alu_result;
      FWD_MEMWB: fwd_rs2 = memwb_wr_data;
      default:   fwd_rs2 = idex_rs2_data;
    endcase
  end

  assign op_b = idex_alusrc ? idex_imm : fwd_rs2;

  alu #(.XLEN(XLEN)) u_alu (
    .op     (idex_alu_op),
    .a      (fwd_rs1),
    .b      (op_b),
    .pc     (idex_pc),
    .result (alu_out)
  );

  // Branch condition; funct3 010/011 never take
  always_comb begin
    taken = 1'b0;
    case (idex_funct3)
      F3_BEQ:  taken = (fwd_rs1 == fwd_rs2);
      F3_BNE:  taken = (fwd_rs1 != fwd_rs2);
      F3_BLT:  taken = ($signed(fwd_rs1) < $signed(fwd_rs2));
      F3_BGE:  taken = ($signed(fwd_rs1) >= $signed(fwd_rs2));
      F3_BLTU: taken = (fwd_rs1 < fwd_rs2);
      F3_BGEU: taken = (fwd_rs1 >= fwd_rs2);
      default: taken = 1'b0;
    endcase
  end

  assign is_jump        = idex_jal | idex_jalr;
  assign jalr_sum       = fwd_rs1 + idex_imm;
  assign redirect_pc    = idex_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (idex_pc + idex_imm);
  assign redirect_valid = idex_valid & ~stall & ~rst & (is_jump | (idex_branch & taken));
  assign ex_result      = is_jump ? (idex_pc + XLEN'(4)) : alu_out;

  // EX/MEM register: reset > flush > stall > load; invalid loads become bubbles
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !idex_valid)) begin
      exmem_valid      <= 1'b0;
      exmem_alu_result <= '0;
      exmem_store_data <= '0;
      exmem_rd         <= '0;
      exmem_regwr      <= 1'b0;
      exmem_memrd      <= 1'b0;
      exmem_memwr      <= 1'b0;
      exmem_memtoreg   <= 1'b0;
      exmem_funct3     <= '0;
    end else if (!stall) begin
      exmem_valid      <= 1'b1;
      exmem_alu_result <= ex_result;
      exmem_store_data <= fwd_rs2;
      exmem_rd         <= idex_rd;
      exmem_regwr      <= idex_regwr;
      exmem_memrd      <= idex_memrd;
      exmem_memwr      <= idex_memwr;
      exmem_memtoreg   <= idex_memtoreg;
      exmem_funct3     <= idex_funct3;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        regwr;
    logic        memrd;
    logic        memwr;
    logic        memtoreg;
    logic [2:0]  f3;
  } exmem_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, idex_valid;
  logic [31:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm, memwb_wr_data;
  logic [4:0]  idex_rd;
  logic [3:0]  idex_alu_op;
  logic        idex_alusrc, idex_regwr, idex_memrd, idex_memwr, idex_memtoreg;
  logic [2:0]  idex_funct3;
  logic        idex_branch, idex_jal, idex_jalr;
  logic [1:0]  forwardA, forwardB;
  logic        exmem_valid, exmem_regwr, exmem_memrd, exmem_memwr, exmem_memtoreg;
  logic [31:0] exmem_alu_result, exmem_store_data, redirect_pc;
  logic [4:0]  exmem_rd;
  logic [2:0]  exmem_funct3;
  logic        redirect_valid;

  exmem_t obs;
  exmem_t model;
  exmem_t held;
  int checks = 0;
  int errors = 0;

  assign obs = {exmem_valid, exmem_alu_result, exmem_store_data, exmem_rd, exmem_regwr,
                exmem_memrd, exmem_memwr, exmem_memtoreg, exmem_funct3};

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .idex_valid(idex_valid),
    .idex_pc(idex_pc), .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data),
    .idex_imm(idex_imm), .idex_rd(idex_rd), .idex_alu_op(idex_alu_op), .idex_alusrc(idex_alusrc),
    .idex_regwr(idex_regwr), .idex_memrd(idex_memrd), .idex_memwr(idex_memwr),
    .idex_memtoreg(idex_memtoreg), .idex_funct3(idex_funct3), .idex_branch(idex_branch),
    .idex_jal(idex_jal), .idex_jalr(idex_jalr), .forwardA(forwardA), .forwardB(forwardB),
    .memwb_wr_data(memwb_wr_data), .exmem_valid(exmem_valid), .exmem_alu_result(exmem_alu_result),
    .exmem_store_data(exmem_store_data), .exmem_rd(exmem_rd), .exmem_regwr(exmem_regwr),
    .exmem_memrd(exmem_memrd), .exmem_memwr(exmem_memwr), .exmem_memtoreg(exmem_memtoreg),
    .exmem_funct3(exmem_funct3), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Reference ALU written from the instruction semantics
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] pc);
    int unsigned sh;
    logic [31:0] fill;
    sh = int'(b % 32);
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    case (op)
      0:  return a + b;
      1:  return a + ~b + 32'd1;
      2:  return a * (32'd1 << sh);
      3:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return (a | b) & ~(a & b);
      6:  return a / (32'd1 << sh);
      7:  return (a >> sh) | fill;
      8:  return a | b;
      9:  return a & b;
      10: return b;
      11: return pc + b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit slt;
    slt = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return slt;
      3'd5: return !slt;
      3'd6: return a < b;
      3'd7: return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] idex_v,
                                       input logic [31:0] prev_alu, input logic [31:0] wb);
    if (sel == 2'b10) return prev_alu;
    if (sel == 2'b01) return wb;
    return idex_v;
  endfunction

  task automatic idle();
    stall = 0; flush = 0; idex_valid = 0; idex_pc = 0; idex_rs1_data = 0; idex_rs2_data = 0;
    idex_imm = 0; idex_rd = 0; idex_alu_op = 0; idex_alusrc = 0; idex_regwr = 0; idex_memrd = 0;
    idex_memwr = 0; idex_memtoreg = 0; idex_funct3 = 0; idex_branch = 0; idex_jal = 0;
    idex_jalr = 0; forwardA = 0; forwardB = 0; memwb_wr_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    idex_valid = 1; idex_jal = 1; idex_pc = 32'h200; idex_imm = 32'h10; idex_regwr = 1;
    #1;
    checks++;
    if (redirect_valid !== 1'b0) begin
      errors++; $display("FAIL reset_redirect got %b want 0", redirect_valid);
    end
    tick(); tick();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_state got %h want 0", obs);
    end
    rst = 0; idle();
  endtask

  task automatic test_add_forward();
    idle();
    idex_valid = 1; idex_alu_op = 4'd0; idex_alusrc = 1; idex_imm = 32'd5; idex_regwr = 1; idex_rd = 5'd3;
    tick();
    checks++;
    if (exmem_alu_result !== 32'd5) begin
      errors++; $display("FAIL addi_setup got %h want 5", exmem_alu_result);
    end
    idex_alusrc = 0; idex_imm = 0; idex_rs1_data = 32'd100; idex_rs2_data = 32'd200;
    forwardA = 2'b10; forwardB = 2'b01; memwb_wr_data = 32'd7; idex_rd = 5'd4;
    tick();
    checks++;
    if (exmem_alu_result !== 32'd12 || exmem_store_data !== 32'd7) begin
      errors++; $display("FAIL add_forward got %h/%h want 0000000c/00000007", exmem_alu_result, exmem_store_data);
    end
  endtask

  task automatic test_branch();
    idle();
    idex_valid = 1; idex_branch = 1; idex_funct3 = 3'b100; idex_rs1_data = 32'hFFFF_FFFF;
    idex_rs2_data = 32'd1; idex_pc = 32'h100; idex_imm = 32'h20;
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120) begin
      errors++; $display("FAIL blt_taken got %b/%h want 1/00000120", redirect_valid, redirect_pc);
    end
    idex_funct3 = 3'b110;
    #1;
    checks++;
    if (redirect_valid !== 1'b0) begin
      errors++; $display("FAIL bltu_not_taken got %b want 0", redirect_valid);
    end
    tick();
  endtask

  task automatic test_jalr();
    idle();
    idex_valid = 1; idex_jalr = 1; idex_rs1_data = 32'h1003; idex_imm = 32'd2; idex_pc = 32'h40;
    idex_alusrc = 1; idex_regwr = 1; idex_rd = 5'd1;
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1004) begin
      errors++; $display("FAIL jalr_target got %b/%h want 1/00001004", redirect_valid, redirect_pc);
    end
    tick();
    checks++;
    if (exmem_alu_result !== 32'h44 || exmem_regwr !== 1'b1 || exmem_valid !== 1'b1) begin
      errors++; $display("FAIL jalr_link got %h/%b/%b want 00000044/1/1", exmem_alu_result, exmem_regwr, exmem_valid);
    end
  endtask

  task automatic test_stall();
    idle();
    idex_valid = 1; idex_alu_op = 4'd0; idex_alusrc = 1; idex_imm = 32'h55; idex_rs2_data = 32'h99;
    idex_regwr = 1; idex_rd = 5'd7;
    tick();
    held = '{valid: 1'b1, alu: 32'h55, store: 32'h99, rd: 5'd7, regwr: 1'b1, memrd: 1'b0,
             memwr: 1'b0, memtoreg: 1'b0, f3: 3'd0};
    for (int i = 0; i < 3; i++) begin
      stall = 1; idex_jal = 1; idex_pc = $urandom; idex_imm = $urandom; idex_rd = 5'($urandom);
      idex_rs2_data = $urandom; idex_memwr = 1'($urandom);
      #1;
      checks++;
      if (redirect_valid !== 1'b0) begin
        errors++; $display("FAIL stall_redirect cycle %0d got %b want 0", i, redirect_valid);
      end
      tick();
      checks++;
      if (obs !== held) begin
        errors++; $display("FAIL stall_hold cycle %0d got %h want %h", i, obs, held);
      end
    end
  endtask

  task automatic test_stall_flush();
    idle();
    idex_valid = 1; idex_regwr = 1; idex_rd = 5'd9; idex_imm = 32'h1234; idex_alusrc = 1;
    stall = 1; flush = 1;
    tick();
    checks++;
    if (exmem_valid !== 1'b0 || exmem_regwr !== 1'b0 || obs !== '0) begin
      errors++; $display("FAIL stall_flush got %h want 0", obs);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    idex_valid = 1; idex_regwr = 1; idex_rd = 5'd2; idex_alusrc = 1; idex_imm = 32'h77;
    tick();
    idex_regwr = 0; idex_rd = 0; idex_memwr = 1; idex_funct3 = 3'b010; idex_imm = 32'd8;
    idex_rs1_data = 32'h1000; idex_rs2_data = 32'hDEAD; rst = 1;
    tick();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_mid got %h want 0", obs);
    end
    rst = 0; idex_valid = 0;
    tick();
    checks++;
    if (exmem_memwr !== 1'b0 || obs !== '0) begin
      errors++; $display("FAIL invalid_bubble got %h want 0", obs);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, opb, exp_pc;
    bit exp_rv, jump;
    exmem_t nxt;
    model = '0;
    for (int n = 0; n < 400; n++) begin
      int unsigned kind;
      idle();
      rst = ($urandom_range(0, 63) == 0); flush = ($urandom_range(0, 15) == 0);
      stall = ($urandom_range(0, 7) == 0); idex_valid = ($urandom_range(0, 5) != 0);
      idex_pc = {$urandom_range(0, 32'h3FFF), 2'b00}; idex_rs1_data = $urandom;
      idex_rs2_data = ($urandom_range(0, 3) == 0) ? idex_rs1_data : $urandom;
      idex_imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
      idex_rd = 5'($urandom); idex_alu_op = 4'($urandom); idex_alusrc = 1'($urandom);
      idex_regwr = 1'($urandom); idex_memrd = 1'($urandom); idex_memwr = 1'($urandom);
      idex_memtoreg = 1'($urandom); idex_funct3 = 3'($urandom);
      forwardA = 2'($urandom); forwardB = 2'($urandom); memwb_wr_data = $urandom;
      kind = $urandom_range(0, 5);
      idex_branch = (kind == 1 || kind == 2); idex_jal = (kind == 3); idex_jalr = (kind == 4);

      a = pick(forwardA, idex_rs1_data, model.alu, memwb_wr_data);
      b = pick(forwardB, idex_rs2_data, model.alu, memwb_wr_data);
      opb = idex_alusrc ? idex_imm : b;
      jump = idex_jal || idex_jalr;
      exp_rv = idex_valid && !stall && !rst && (jump || (idex_branch && ref_taken(idex_funct3, a, b)));
      exp_pc = idex_jalr ? ((a + idex_imm) & 32'hFFFF_FFFE) : (idex_pc + idex_imm);
      #1;
      checks++;
      if (redirect_valid !== exp_rv || (exp_rv && redirect_pc !== exp_pc)) begin
        errors++; $display("FAIL rand_redirect iter %0d got %b/%h want %b/%h", n, redirect_valid, redirect_pc, exp_rv, exp_pc);
      end

      if (rst || flush || (!stall && !idex_valid)) nxt = '0;
      else if (stall) nxt = model;
      else nxt = '{valid: 1'b1, alu: jump ? idex_pc + 32'd4 : ref_alu(int'(idex_alu_op), a, opb, idex_pc),
                   store: b, rd: idex_rd, regwr: idex_regwr, memrd: idex_memrd, memwr: idex_memwr,
                   memtoreg: idex_memtoreg, f3: idex_funct3};
      tick();
      model = nxt;
      checks++;
      if (obs !== model) begin
        errors++; $display("FAIL rand_exmem iter %0d got %h want %h", n, obs, model);
      end
    end
    rst = 0; idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_add_forward();
    test_branch();
    test_jalr();
    test_stall();
    test_stall_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32I pipeline. It takes decoded operands and control from the ID/EX register and resolves operand sources from the forwarding select codes. It performs the ALU operation and resolves branches and jumps into a PC redirect, then registers the result and control into the EX/MEM pipeline register. Its EX/MEM outputs feed the MEM stage and also return to the forwarding logic as `exmem_rd` and `exmem_regwr`.

## Interface
Parameters:
- `XLEN`, 32, datapath width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold the EX/MEM register and suppress redirect.
- `flush`  in  1  load a bubble into EX/MEM on the next edge.
- `idex_valid`  in  1  ID/EX holds a real instruction.
- `idex_pc`  in  XLEN  instruction PC.
- `idex_rs1_data`, `idex_rs2_data`  in  XLEN  register-file operands.
- `idex_imm`  in  XLEN  sign-extended immediate.
- `idex_rd`  in  5  destination register.
- `idex_alu_op`  in  4  ALU operation code.
- `idex_alusrc`  in  1  operand B select: 1 = imm, 0 = forwarded rs2.
- `idex_regwr`, `idex_memrd`, `idex_memwr`, `idex_memtoreg`  in  1  control bits passed through to EX/MEM.
- `idex_funct3`  in  3  branch condition and memory size.
- `idex_branch`, `idex_jal`, `idex_jalr`  in  1  control-flow type.
- `forwardA`, `forwardB`  in  2  forwarding selects for rs1 and rs2.
- `memwb_wr_data`  in  XLEN  MEM/WB write-back value.
- `exmem_valid`  out  1  EX/MEM holds a real instruction.
- `exmem_alu_result`  out  XLEN  registered ALU result, or link address for jumps.
- `exmem_store_data`  out  XLEN  forwarded rs2 value, for stores.
- `exmem_rd`  out  5  registered destination register.
- `exmem_regwr`, `exmem_memrd`, `exmem_memwr`, `exmem_memtoreg`  out  1  registered control bits.
- `exmem_funct3`  out  3  registered funct3.
- `redirect_valid`  out  1  taken branch or jump this cycle (combinational).
- `redirect_pc`  out  XLEN  redirect target (combinational).

## Operation
- Forward mux for operand A and operand B:
  - `00` selects the ID/EX value.
  - `10` selects `exmem_alu_result`.
  - `01` selects `memwb_wr_data`.
  - `11` is treated as `00`.
- `opB = idex_alusrc ? idex_imm : fwd_rs2`.
- ALU operations, all results XLEN bits, wrap-around arithmetic:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU.
  - 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 PASSB (LUI), 11 PCADD (`pc + opB`, for AUIPC).
  - Codes 12–15 produce 0.
  - Shift amount is `opB[4:0]`.
- Branch condition compares `fwd_rs1` with `fwd_rs2` by `funct3`:
  - 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - 010 and 011 are never taken.
- Redirect target:
  - branch or JAL: `pc + imm`.
  - JALR: `(fwd_rs1 + imm) & ~1`.
- `redirect_valid = idex_valid & !stall & !rst & (jal | jalr | (branch & cond))`.
- For JAL/JALR the registered result is `pc + 4`; otherwise it is the ALU result.
- EX/MEM update priority, highest first:
  1. `rst`: all EX/MEM outputs go to 0.
  2. `flush`: bubble.
  3. `stall`: hold all outputs.
  4. Otherwise: load.
- Loading while `idex_valid = 0` also produces a bubble.
- A bubble has `exmem_valid`, `regwr`, `memrd`, `memwr` and `memtoreg` all 0; the data fields are don't-care but are driven to 0. Zeroing `regwr` guarantees no false forward match downstream.

## Timing
- Reset value of every `exmem_*` output is 0. `redirect_valid` is 0 while `rst` is high.
- Latency is one cycle from ID/EX inputs to `exmem_*` outputs.
- `redirect_*` is combinational in the same cycle. The front end uses it to flush IF/ID and ID/EX, not EX/MEM.
- `forwardA = 10` reads the current `exmem_alu_result`, i.e. the result of the previous instruction. There is no combinational loop, because the path goes through the register.
- If `stall` and `flush` are asserted together, the flush wins.
- A redirect is never issued while `stall` is high. The instruction re-evaluates when the stall releases.
- Reset asserted mid-stream clears EX/MEM on that edge. Any in-flight redirect is dropped.
- Back-to-back taken branches: each one redirects in its own EX cycle. The second only arrives if the front end did not squash it.

## Structure
- Shared package `riscv_pkg` holds:
  - ALU op constants `ALU_ADD` … `ALU_PCADD`.
  - Branch `funct3` constants.
  - Forward-select constants `FWD_IDEX`, `FWD_EXMEM`, `FWD_MEMWB`.
- Sub-module `alu` is purely combinational: op, a, b, pc → result.
- `ex_stage` contains the forward muxes, branch compare, redirect logic and the EX/MEM register.

## Test plan
- ADD with forwardA=`10`, forwardB=`01`, `exmem_alu_result=5`, `memwb_wr_data=7` → next cycle `exmem_alu_result=12`.
- BLT with rs1=`0xFFFFFFFF`, rs2=1, pc=`0x100`, imm=`0x20` → `redirect_valid=1`, `redirect_pc=0x120`. Same operands with BLTU → not taken.
- JALR with rs1=`0x1003`, imm=2, pc=`0x40` → `redirect_pc=0x1004`; next cycle `exmem_alu_result=0x44`, `exmem_regwr=1`.
- Load an instruction, then assert `stall` for 3 cycles with changing inputs → `exmem_*` outputs unchanged and `redirect_valid=0` throughout.
- Assert `stall` and `flush` in the same cycle → `exmem_valid=0`, `exmem_regwr=0` on the next edge.
- Assert `rst` mid-stream with a valid SW in ID/EX → all `exmem_*` outputs 0 next cycle; `idex_valid=0` then yields a bubble with `exmem_memwr=0`.
